// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keystroke sequencer: key codes,
// operator encodings, FSM states and small key-classification helpers.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_BS    = 4'hF;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    ENTA = 3'd0,
    ENTB = 3'd1,
    CALC = 3'd2,
    RES  = 3'd3,
    ERR  = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] code);
    return (code >= KEY_PLUS) && (code <= KEY_DIV);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Packed-BCD operand entry register: shifts digits in from the right,
// backspace shifts them out, with a digit count saturating at NDIG.
module bcd_entry_reg #(
  parameter int NDIG = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [3:0]                 digit,
  output logic [4*NDIG-1:0]          value,
  output logic [$clog2(NDIG+1)-1:0]  count
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] FULL = CW'(NDIG);

  logic [W-1:0]  val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A clear may coincide with a push so a fresh entry can start in one key
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clear) begin
      val_d = push ? W'(digit) : '0;
      cnt_d = push ? CW'(1) : '0;
    end else if (push) begin
      if (cnt_q != FULL) begin
        val_d = {val_q[W-5:0], digit};
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop) begin
      if (cnt_q != '0) begin
        val_d = val_q >> 4;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign value = val_q;
  assign count = cnt_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator keystroke sequencer: assembles two BCD operands and an operator,
// launches and supervises the ALU, and selects the displayed value.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int ALU_TIMEOUT = 1023
) (
  input  logic                iCLK_50,
  input  logic                iRST_n,
  input  logic [3:0]          char_code,
  input  logic                char_valid,
  input  logic                alu_done,
  input  logic                alu_err,
  input  logic [4*NDIG-1:0]   alu_result,
  output logic [4*NDIG-1:0]   op_a,
  output logic [4*NDIG-1:0]   op_b,
  output logic [1:0]          op_code,
  output logic                alu_start,
  output logic                busy,
  output logic [4*NDIG-1:0]   disp_bcd,
  output logic                err
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  state_t         state_q, state_d;
  logic           cv_q;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   res_q, res_d;
  logic           start_q, start_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic           push_a, pop_a, clr_a;
  logic           push_b, pop_b, clr_b;
  logic [W-1:0]   a_val, b_val;
  logic [CW-1:0]  a_cnt, b_cnt;
  logic           kev;

  // cv_q resets high so a key already held at reset release is not an event
  assign kev = char_valid & ~cv_q;

  bcd_entry_reg #(.NDIG(NDIG)) u_reg_a (
    .clk   (iCLK_50),
    .rst_n (iRST_n),
    .push  (push_a),
    .pop   (pop_a),
    .clear (clr_a),
    .digit (char_code),
    .value (a_val),
    .count (a_cnt)
  );

  bcd_entry_reg #(.NDIG(NDIG)) u_reg_b (
    .clk   (iCLK_50),
    .rst_n (iRST_n),
    .push  (push_b),
    .pop   (pop_b),
    .clear (clr_b),
    .digit (char_code),
    .value (b_val),
    .count (b_cnt)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    push_a  = 1'b0;
    pop_a   = 1'b0;
    clr_a   = 1'b0;
    push_b  = 1'b0;
    pop_b   = 1'b0;
    clr_b   = 1'b0;

    case (state_q)
      ENTA: begin
        if (kev) begin
          if (is_digit(char_code)) begin
            push_a = 1'b1;
          end else if (is_op(char_code)) begin
            if (a_cnt != '0) begin
              op_d    = 2'(char_code - KEY_PLUS);
              state_d = ENTB;
            end
          end else if (char_code == KEY_BS) begin
            pop_a = 1'b1;
          end
        end
      end

      ENTB: begin
        if (kev) begin
          if (is_digit(char_code)) begin
            push_b = 1'b1;
          end else if (is_op(char_code)) begin
            if (b_cnt == '0) op_d = 2'(char_code - KEY_PLUS);
          end else if (char_code == KEY_BS) begin
            if (b_cnt != '0) pop_b = 1'b1;
            else             state_d = ENTA;
          end else if (b_cnt != '0) begin
            state_d = CALC;
            start_d = 1'b1;
            tmo_d   = '0;
          end
        end
      end

      CALC: begin
        // A done coinciding with the launch strobe belongs to no request of ours
        if (alu_done && !start_q) begin
          if (alu_err) begin
            state_d = ERR;
          end else begin
            res_d   = alu_result;
            state_d = RES;
          end
        end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RES: begin
        if (kev) begin
          if (is_digit(char_code)) begin
            clr_a   = 1'b1;
            clr_b   = 1'b1;
            push_a  = 1'b1;
            state_d = ENTA;
          end else if (char_code == KEY_BS) begin
            clr_a   = 1'b1;
            clr_b   = 1'b1;
            res_d   = '0;
            op_d    = OP_ADD;
            state_d = ENTA;
          end
        end
      end

      ERR: begin
        if (kev && char_code == KEY_BS) begin
          clr_a   = 1'b1;
          clr_b   = 1'b1;
          res_d   = '0;
          op_d    = OP_ADD;
          state_d = ENTA;
        end
      end

      default: state_d = ENTA;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (!iRST_n) begin
      state_q <= ENTA;
      cv_q    <= 1'b1;
      op_q    <= OP_ADD;
      res_q   <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cv_q    <= char_valid;
      op_q    <= op_d;
      res_q   <= res_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    disp_bcd = '0;
    case (state_q)
      ENTA:    disp_bcd = a_val;
      ENTB:    disp_bcd = (b_cnt != '0) ? b_val : a_val;
      CALC:    disp_bcd = b_val;
      RES:     disp_bcd = res_q;
      default: disp_bcd = '0;
    endcase
  end

  assign op_a      = a_val;
  assign op_b      = b_val;
  assign op_code   = op_q;
  assign alu_start = start_q;
  assign busy      = (state_q == CALC);
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: a key-by-key vector table for operand
// entry, plus hand sequences for CALC handshake, timeout, errors and reset.
module tb_calc_entry_ctrl;

  localparam int NDIG = 4;
  localparam int TMO  = 1023;

  logic        iCLK_50 = 1'b0;
  logic        iRST_n;
  logic [3:0]  char_code;
  logic        char_valid;
  logic        alu_done;
  logic        alu_err;
  logic [15:0] alu_result;
  logic [15:0] op_a, op_b, disp_bcd;
  logic [1:0]  op_code;
  logic        alu_start, busy, err;

  int checks = 0;
  int errors = 0;

  calc_entry_ctrl #(.NDIG(NDIG), .ALU_TIMEOUT(TMO)) dut (
    .iCLK_50    (iCLK_50),
    .iRST_n     (iRST_n),
    .char_code  (char_code),
    .char_valid (char_valid),
    .alu_done   (alu_done),
    .alu_err    (alu_err),
    .alu_result (alu_result),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_code    (op_code),
    .alu_start  (alu_start),
    .busy       (busy),
    .disp_bcd   (disp_bcd),
    .err        (err)
  );

  always #5 iCLK_50 = ~iCLK_50;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] disp;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    char_code  = c;
    char_valid = 1'b1;
    @(negedge iCLK_50);
    char_valid = 1'b0;
    @(negedge iCLK_50);
  endtask

  task automatic do_reset();
    iRST_n     = 1'b0;
    char_valid = 1'b0;
    alu_done   = 1'b0;
    alu_err    = 1'b0;
    @(negedge iCLK_50);
    @(negedge iCLK_50);
    iRST_n = 1'b1;
    @(negedge iCLK_50);
  endtask

  task automatic enter_calc();
    char_code  = 4'hE;
    char_valid = 1'b1;
    @(negedge iCLK_50);
    char_valid = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".op_a"}, op_a, 16'h0000);
    chk({tag, ".op_b"}, op_b, 16'h0000);
    chk({tag, ".op_code"}, {14'b0, op_code}, 16'h0000);
    chk({tag, ".disp"}, disp_bcd, 16'h0000);
    chk({tag, ".busy"}, {15'b0, busy}, 16'h0000);
    chk({tag, ".err"}, {15'b0, err}, 16'h0000);
    chk({tag, ".start"}, {15'b0, alu_start}, 16'h0000);
  endtask

  initial begin
    vecs[0]  = '{4'h1, 16'h0001, 16'h0000, 2'd0, 16'h0001};
    vecs[1]  = '{4'h2, 16'h0012, 16'h0000, 2'd0, 16'h0012};
    vecs[2]  = '{4'h3, 16'h0123, 16'h0000, 2'd0, 16'h0123};
    vecs[3]  = '{4'h4, 16'h1234, 16'h0000, 2'd0, 16'h1234};
    vecs[4]  = '{4'h5, 16'h1234, 16'h0000, 2'd0, 16'h1234};
    vecs[5]  = '{4'hF, 16'h0123, 16'h0000, 2'd0, 16'h0123};
    vecs[6]  = '{4'hA, 16'h0123, 16'h0000, 2'd0, 16'h0123};
    vecs[7]  = '{4'hC, 16'h0123, 16'h0000, 2'd2, 16'h0123};
    vecs[8]  = '{4'hD, 16'h0123, 16'h0000, 2'd3, 16'h0123};
    vecs[9]  = '{4'hE, 16'h0123, 16'h0000, 2'd3, 16'h0123};
    vecs[10] = '{4'hF, 16'h0123, 16'h0000, 2'd3, 16'h0123};
    vecs[11] = '{4'h4, 16'h1234, 16'h0000, 2'd3, 16'h1234};
    vecs[12] = '{4'hB, 16'h1234, 16'h0000, 2'd1, 16'h1234};
    vecs[13] = '{4'h9, 16'h1234, 16'h0009, 2'd1, 16'h0009};
    vecs[14] = '{4'hC, 16'h1234, 16'h0009, 2'd1, 16'h0009};
    vecs[15] = '{4'h7, 16'h1234, 16'h0097, 2'd1, 16'h0097};
    vecs[16] = '{4'hF, 16'h1234, 16'h0009, 2'd1, 16'h0009};
    vecs[17] = '{4'hF, 16'h1234, 16'h0000, 2'd1, 16'h1234};
    vecs[18] = '{4'hF, 16'h1234, 16'h0000, 2'd1, 16'h1234};
    vecs[19] = '{4'hF, 16'h0123, 16'h0000, 2'd1, 16'h0123};
    vecs[20] = '{4'hF, 16'h0012, 16'h0000, 2'd1, 16'h0012};
    vecs[21] = '{4'hF, 16'h0001, 16'h0000, 2'd1, 16'h0001};
    vecs[22] = '{4'hF, 16'h0000, 16'h0000, 2'd1, 16'h0000};
    vecs[23] = '{4'hF, 16'h0000, 16'h0000, 2'd1, 16'h0000};
    vecs[24] = '{4'hA, 16'h0000, 16'h0000, 2'd1, 16'h0000};
    vecs[25] = '{4'hE, 16'h0000, 16'h0000, 2'd1, 16'h0000};
    vecs[26] = '{4'h1, 16'h0001, 16'h0000, 2'd1, 16'h0001};
    vecs[27] = '{4'h2, 16'h0012, 16'h0000, 2'd1, 16'h0012};
    vecs[28] = '{4'hF, 16'h0001, 16'h0000, 2'd1, 16'h0001};
    vecs[29] = '{4'h7, 16'h0017, 16'h0000, 2'd1, 16'h0017};
    vecs[30] = '{4'hA, 16'h0017, 16'h0000, 2'd0, 16'h0017};
    vecs[31] = '{4'hF, 16'h0017, 16'h0000, 2'd0, 16'h0017};
    vecs[32] = '{4'hF, 16'h0001, 16'h0000, 2'd0, 16'h0001};

    char_code  = 4'h0;
    alu_result = 16'h0000;
    do_reset();
    chk_idle_zero("reset");

    // operand entry table
    for (int i = 0; i < NV; i++) begin
      press(vecs[i].key);
      $display("vec %0d key %h a %h b %h op %0d disp %h", i, vecs[i].key, op_a, op_b, op_code, disp_bcd);
      chk($sformatf("vec%0d.a", i), op_a, vecs[i].a);
      chk($sformatf("vec%0d.b", i), op_b, vecs[i].b);
      chk($sformatf("vec%0d.op", i), {14'b0, op_code}, {14'b0, vecs[i].op});
      chk($sformatf("vec%0d.disp", i), disp_bcd, vecs[i].disp);
      chk($sformatf("vec%0d.busy", i), {15'b0, busy}, 16'h0000);
    end

    // 12 + 34 through the ALU handshake
    do_reset();
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
    enter_calc();
    $display("seq add: enter start %b busy %b", alu_start, busy);
    chk("add.start", {15'b0, alu_start}, 16'h0001);
    chk("add.busy", {15'b0, busy}, 16'h0001);
    chk("add.op_a", op_a, 16'h0012);
    chk("add.op_b", op_b, 16'h0034);
    chk("add.op_code", {14'b0, op_code}, 16'h0000);
    chk("add.disp_calc", disp_bcd, 16'h0034);
    alu_done   = 1'b1;
    alu_result = 16'h1111;
    @(negedge iCLK_50);
    alu_done = 1'b0;
    chk("add.start_one_cycle", {15'b0, alu_start}, 16'h0000);
    chk("add.done_in_start_ignored", {15'b0, busy}, 16'h0001);
    press(4'h7);
    $display("seq add: key during calc op_b %h busy %b", op_b, busy);
    chk("add.key_dropped_b", op_b, 16'h0034);
    chk("add.key_dropped_busy", {15'b0, busy}, 16'h0001);
    @(negedge iCLK_50);
    char_code  = 4'h9;
    char_valid = 1'b1;
    alu_done   = 1'b1;
    alu_result = 16'h0046;
    @(negedge iCLK_50);
    alu_done   = 1'b0;
    char_valid = 1'b0;
    $display("seq add: done disp %h busy %b", disp_bcd, busy);
    chk("add.disp_res", disp_bcd, 16'h0046);
    chk("add.busy_done", {15'b0, busy}, 16'h0000);
    chk("add.err", {15'b0, err}, 16'h0000);
    chk("add.key_with_done_dropped", op_a, 16'h0012);
    @(negedge iCLK_50);
    press(4'h7);
    $display("seq add: new digit a %h b %h disp %h", op_a, op_b, disp_bcd);
    chk("res.digit_a", op_a, 16'h0007);
    chk("res.digit_b", op_b, 16'h0000);
    chk("res.digit_disp", disp_bcd, 16'h0007);

    // key level held through reset release, then a new rise held long
    iRST_n     = 1'b0;
    char_code  = 4'h5;
    char_valid = 1'b1;
    @(negedge iCLK_50);
    iRST_n = 1'b1;
    repeat (10) @(negedge iCLK_50);
    chk("hold.no_event_at_release", op_a, 16'h0000);
    char_valid = 1'b0;
    @(negedge iCLK_50);
    char_valid = 1'b1;
    repeat (10) @(negedge iCLK_50);
    char_valid = 1'b0;
    @(negedge iCLK_50);
    $display("seq hold: a %h", op_a);
    chk("hold.one_digit", op_a, 16'h0005);

    // 8 / 0 with ALU error
    do_reset();
    press(4'h8); press(4'hD); press(4'h0);
    enter_calc();
    @(negedge iCLK_50);
    alu_done = 1'b1;
    alu_err  = 1'b1;
    @(negedge iCLK_50);
    alu_done = 1'b0;
    alu_err  = 1'b0;
    $display("seq diverr: err %b disp %h busy %b", err, disp_bcd, busy);
    chk("diverr.err", {15'b0, err}, 16'h0001);
    chk("diverr.disp", disp_bcd, 16'h0000);
    chk("diverr.busy", {15'b0, busy}, 16'h0000);
    press(4'h3);
    chk("diverr.digit_ignored", {15'b0, err}, 16'h0001);
    press(4'hF);
    chk_idle_zero("diverr_clr");

    // same entry, no done: timeout
    press(4'h8); press(4'hD); press(4'h0);
    enter_calc();
    repeat (TMO - 1) @(negedge iCLK_50);
    chk("tmo.err_before", {15'b0, err}, 16'h0000);
    chk("tmo.busy_before", {15'b0, busy}, 16'h0001);
    @(negedge iCLK_50);
    $display("seq timeout: err %b busy %b", err, busy);
    chk("tmo.err_at", {15'b0, err}, 16'h0001);
    chk("tmo.busy_at", {15'b0, busy}, 16'h0000);
    press(4'hF);
    chk_idle_zero("tmo_clr");

    // reset during CALC, then a late done
    press(4'h1); press(4'hA); press(4'h2);
    enter_calc();
    repeat (3) @(negedge iCLK_50);
    iRST_n = 1'b0;
    @(negedge iCLK_50);
    iRST_n = 1'b1;
    $display("seq rst_calc: busy %b a %h b %h", busy, op_a, op_b);
    chk_idle_zero("rst_calc");
    alu_done   = 1'b1;
    alu_result = 16'h9999;
    @(negedge iCLK_50);
    alu_done = 1'b0;
    chk_idle_zero("late_done");
    press(4'h3);
    chk("late_done.enta", op_a, 16'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keystroke sequencer for the calculator. It consumes decoded key events (`char_code`/`char_valid`) from the PS/2 front end and assembles two BCD operands and an operator. It launches the arithmetic unit through a start/done handshake, supervises that unit with a timeout, and drives the value the display shows.

## Interface
- `NDIG`, 4, digits per operand; operands and result are `4*NDIG` bits of packed BCD.
- `ALU_TIMEOUT`, 1023, maximum CALC cycles to wait for `alu_done` before flagging an error.
- `iCLK_50`  in  1  system clock; the only clock.
- `iRST_n`  in  1  reset, synchronous, active-low.
- `char_code`  in  4  key code: 0-9 digit, A `+`, B `-`, C `*`, D `/`, E Enter, F Backspace/clear.
- `char_valid`  in  1  key-present level. Only its rising edge is an event.
- `alu_done`  in  1  one-cycle completion strobe from the ALU.
- `alu_err`  in  1  ALU error (divide by zero or overflow), sampled with `alu_done`.
- `alu_result`  in  4*NDIG  BCD result, sampled with `alu_done`.
- `op_a`, `op_b`  out  4*NDIG  BCD operands.
- `op_code`  out  2  operator: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- `alu_start`  out  1  one-cycle launch strobe.
- `busy`  out  1  high in CALC.
- `disp_bcd`  out  4*NDIG  value for the display.
- `err`  out  1  high in ERR.

## Operation
- Key event: `kev = char_valid & ~cv_q`, where `cv_q` is `char_valid` registered.
  - `cv_q` resets to 1, so a level that is already high when reset releases is not an event.
- Each operand is held in a BCD entry register with a digit count of 0..NDIG.
  - Push: `{reg[4*NDIG-5:0], d}` and count+1. Ignored when count == NDIG.
  - Pop: `reg >> 4` and count-1. Ignored when count == 0.
- ENTA (reset state):
  - Digit: push to A.
  - Operator: if cntA > 0, latch `op_code` (code minus 0xA) and go to ENTB. Otherwise ignored.
  - Backspace: pop A.
  - Enter: ignored.
- ENTB:
  - Digit: push to B.
  - Operator: replaces `op_code` while cntB == 0. Ignored once cntB > 0; there is no chaining.
  - Backspace: pop B if cntB > 0. Otherwise return to ENTA with A unchanged.
  - Enter: if cntB > 0, go to CALC. Otherwise ignored.
- CALC: all key events are dropped.
  - On `alu_done` (not honoured in the start cycle) with `alu_err` = 0: latch `alu_result` and go to RES.
  - On `alu_done` with `alu_err` = 1: go to ERR.
  - If the cycle count reaches `ALU_TIMEOUT` with no done: go to ERR.
- RES:
  - Digit: clear A and B, push the digit to A, go to ENTA.
  - Backspace: clear everything and go to ENTA.
  - Operator or Enter: ignored.
- ERR:
  - Backspace: clear everything and go to ENTA.
  - All other keys: ignored.
- Display:
  - ENTA: A.
  - ENTB: B if cntB > 0, else A.
  - CALC: B.
  - RES: the latched result.
  - ERR: 0.
- Clearing sets A, B, both counts, the result register and `op_code` to 0.

## Timing
- Reset (`iRST_n` low at an edge) takes effect at that edge regardless of state, including mid-CALC:
  - State becomes ENTA; A, B, counts, result, `op_code`, `alu_start`, `busy`, `err` and `disp_bcd` all become 0.
  - A late `alu_done` after reset is ignored.
- Key latency: registers and outputs update at the first edge where `char_valid` is sampled high after being low. They are visible one cycle after the rise.
- Enter accepted at edge k:
  - `state = CALC`, `busy = 1` and `alu_start = 1` from edge k for exactly one cycle.
  - `op_a`, `op_b` and `op_code` are held constant from edge k until CALC exits.
- The timeout counter clears on CALC entry and increments every CALC cycle. It expires at count == `ALU_TIMEOUT`.
- A key event and `alu_done` in the same cycle: done is processed and the key is dropped.
- `alu_done` in a non-CALC state: ignored.

## Structure
- Package `calc_pkg` holds:
  - key-code constants `KEY_PLUS`..`KEY_BS` (0xA-0xF);
  - operator encodings `OP_ADD`..`OP_DIV`;
  - the state enum {ENTA, ENTB, CALC, RES, ERR}.
- Sub-module `bcd_entry_reg`:
  - parameter `NDIG`; inputs push/pop/clear/digit; outputs value and count;
  - instantiated twice, once for A and once for B.
- The top level holds the FSM, edge detect, timeout counter, result latch and display mux.

## Test plan
- Keys 1, 2, +, 3, 4, Enter, then `alu_done` 5 cycles later with result 0x0046 -> `op_a` 0x0012, `op_b` 0x0034, `op_code` 0, `alu_start` high for one cycle, `disp_bcd` 0x0046, `busy` back to 0.
- Keys 1, 2, 3, 4, 5 -> `op_a` 0x1234, fifth digit dropped; then `*` with `*` pressed again while cntB == 0 -> `op_code` 2, still ENTB.
- Keys 1, 2, BS -> 0x0001; then 7, +, BS, BS -> back in ENTA, `op_a` 0x0001 after the second BS (was 0x0017).
- `char_valid` held high 10 cycles with code 5 -> exactly one digit accepted, A = 0x0005.
- 8, /, 0, Enter with done and `alu_err` = 1 -> `err` 1, `disp_bcd` 0; BS -> ENTA, all zero. Repeat with no done -> `err` at `ALU_TIMEOUT` cycles.
- `iRST_n` low for one cycle during CALC -> all outputs 0, ENTA; a later `alu_done` is ignored.
